sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_resp.sv | 119 +++++++++++
 tb/tb_sram_like_resp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_resp
// Purpose  : Fixed-latency responder for an SRAM-like request/response bus.
//            Accepted requests are forwarded to a synchronous RAM in the same
//            cycle. Each request then receives exactly one data_ok pulse
//            1+DATA_DELAY cycles later, so responses stay in acceptance order.
//            Read responses carry the RAM word. Write responses carry zero.
// Ports    : clk, reset (async, active-high)
//            req/wr/size/wstrb/addr/wdata : master request
//            addr_stall                   : blocks acceptance only
//            addr_ok/data_ok/rdata        : handshake + response
//            ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : backing RAM port
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_resp #(
  parameter int RAM_AW      = 16,
  parameter int DATA_DELAY  = 0,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              addr_stall,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             hs_q;       // a handshake happened last cycle
  logic             hs_wr_q;    // ...and it was a write
  logic             handshake;
  logic [31:0]      cap_data;

  // Byte offset, size and the address bits above the RAM window are not used.
  logic unused_ok;
  assign unused_ok = &{1'b0, size, addr};

  // Acceptance looks at the pending count from before this cycle's update.
  // A response retiring in the same cycle therefore does not free a slot
  // until the next cycle.
  assign addr_ok   = req & ~addr_stall & (pending_q < CNT_W'(OUTSTANDING));
  assign handshake = req & addr_ok;

  assign ram_en    = handshake;
  assign ram_we    = (handshake && wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  always_comb begin
    pending_d = pending_q;
    if (handshake && !data_ok) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!handshake && data_ok) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      hs_q      <= 1'b0;
      hs_wr_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      hs_q      <= handshake;
      hs_wr_q   <= handshake & wr;
    end
  end

  // RAM read data is valid in the cycle after the handshake. Write responses
  // and idle cycles are zeroed here, so every later stage carries zero
  // unless it holds a read.
  assign cap_data = (hs_q && !hs_wr_q) ? ram_rdata : 32'h0;

  generate
    if (DATA_DELAY == 0) begin : g_no_delay
      assign data_ok = hs_q;
      assign rdata   = cap_data;
    end else begin : g_delay
      logic [DATA_DELAY-1:0] vld_q;
      logic [31:0]           dat_q [DATA_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int k = 0; k < DATA_DELAY; k++) begin
            dat_q[k] <= 32'h0;
          end
        end else begin
          vld_q[0] <= hs_q;
          dat_q[0] <= cap_data;
          for (int k = 1; k < DATA_DELAY; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign data_ok = vld_q[DATA_DELAY-1];
      assign rdata   = vld_q[DATA_DELAY-1] ? dat_q[DATA_DELAY-1] : 32'h0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_resp
// Purpose  : Directed self-checking bench for sram_like_resp. Four instances
//            use different latency/outstanding settings. Each has its own RAM
//            model, and only one is driven with req at a time.
//            inst0: DATA_DELAY=0 OUTSTANDING=1
//            inst1: DATA_DELAY=2 OUTSTANDING=3
//            inst2: DATA_DELAY=2 OUTSTANDING=1
//            inst3: DATA_DELAY=3 OUTSTANDING=3
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_stall;

  logic        addr_ok   [4];
  logic        data_ok   [4];
  logic [31:0] rdata     [4];
  logic        ram_en    [4];
  logic [3:0]  ram_we    [4];
  logic [15:0] ram_addr  [4];
  logic [31:0] ram_wdata [4];
  logic [31:0] ram_rdata [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int DD = (i == 0) ? 0 : ((i == 3) ? 3 : 2);
    localparam int OO = (i == 1 || i == 3) ? 3 : 1;
    logic [31:0] mem [256];

    sram_like_resp #(.RAM_AW(16), .DATA_DELAY(DD), .OUTSTANDING(OO)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req[i]),
      .wr        (wr),
      .size      (size),
      .wstrb     (wstrb),
      .addr      (addr),
      .wdata     (wdata),
      .addr_stall(addr_stall),
      .addr_ok   (addr_ok[i]),
      .data_ok   (data_ok[i]),
      .rdata     (rdata[i]),
      .ram_en    (ram_en[i]),
      .ram_we    (ram_we[i]),
      .ram_addr  (ram_addr[i]),
      .ram_wdata (ram_wdata[i]),
      .ram_rdata (ram_rdata[i])
    );

    initial begin
      for (int k = 0; k < 256; k++) mem[k] = 32'h5A00_0000 | k;
      mem[0] = 32'h0280_0000;
      mem[4] = 32'h1122_3344;
    end

    // Synchronous RAM: read data (old contents) appears the cycle after ram_en.
    always @(posedge clk) begin
      if (ram_en[i]) begin
        ram_rdata[i] <= mem[ram_addr[i][7:0]];
        for (int b = 0; b < 4; b++) begin
          if (ram_we[i][b]) mem[ram_addr[i][7:0]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 4'b0; wr = 1'b0; addr_stall = 1'b0; wstrb = 4'b0;
  endtask

  logic [31:0] e2 [8];

  initial begin
    reset = 1'b1; idle(); size = 2'b10; addr = 32'h0; wdata = 32'h0;

    // ---- reset state, all instances ----
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_data_ok%0d", i), {31'b0, data_ok[i]}, 32'h0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_ram_en%0d", i), {31'b0, ram_en[i]}, 32'h0);
      check($sformatf("rst_ram_we%0d", i), {28'b0, ram_we[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // ---- inst0 D=0: read 0x1c000000 in the first cycle after reset ----
    step(); req[0] = 1'b1; addr = 32'h1c00_0000;
    @(negedge clk);
    check("t1_addr_ok", {31'b0, addr_ok[0]}, 32'h1);
    check("t1_ram_en", {31'b0, ram_en[0]}, 32'h1);
    check("t1_ram_addr", {16'b0, ram_addr[0]}, 32'h0);
    check("t1_data_ok_c0", {31'b0, data_ok[0]}, 32'h0);
    step(); idle();
    @(negedge clk);
    check("t1_data_ok_c1", {31'b0, data_ok[0]}, 32'h1);
    check("t1_rdata_c1", rdata[0], 32'h0280_0000);
    step();
    @(negedge clk);
    check("t1_data_ok_c2", {31'b0, data_ok[0]}, 32'h0);
    check("t1_rdata_c2", rdata[0], 32'h0);

    // ---- inst1 D=2 O=3: reads 0x0,0x4,0x8 back to back ----
    e2 = '{32'h0, 32'h0, 32'h0, 32'h0280_0000, 32'h5A00_0001, 32'h5A00_0002, 32'h0, 32'h0};
    for (int c = 0; c < 8; c++) begin
      step(); req[1] = (c < 3); addr = 32'(c * 4);
      @(negedge clk);
      if (c < 3) check($sformatf("t2_addr_ok_c%0d", c), {31'b0, addr_ok[1]}, 32'h1);
      check($sformatf("t2_data_ok_c%0d", c), {31'b0, data_ok[1]}, {31'b0, (c >= 3 && c <= 5)});
      check($sformatf("t2_rdata_c%0d", c), rdata[1], e2[c]);
    end
    idle();

    // ---- inst2 D=2 O=1: req held. The slot frees only the cycle after
    //      data_ok, so acceptance repeats every 4 cycles ----
    for (int c = 0; c < 9; c++) begin
      step(); req[2] = 1'b1; addr = 32'h0;
      @(negedge clk);
      check($sformatf("t3_addr_ok_c%0d", c), {31'b0, addr_ok[2]}, {31'b0, (c % 4 == 0)});
      check($sformatf("t3_data_ok_c%0d", c), {31'b0, data_ok[2]}, {31'b0, (c == 3 || c == 7)});
      check($sformatf("t3_rdata_c%0d", c), rdata[2], (c == 3 || c == 7) ? 32'h0280_0000 : 32'h0);
    end
    step(); idle();
    repeat (4) step();

    // ---- inst1: partial write to 0x10, then read it back ----
    step(); req[1] = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = 4'b0011; wdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("t4_w_addr_ok", {31'b0, addr_ok[1]}, 32'h1);
    check("t4_w_ram_we", {28'b0, ram_we[1]}, 32'h3);
    check("t4_w_ram_addr", {16'b0, ram_addr[1]}, 32'h4);
    check("t4_w_ram_wdata", ram_wdata[1], 32'hAABB_CCDD);
    step(); wr = 1'b0; wstrb = 4'b1111;
    @(negedge clk);
    check("t4_r_addr_ok", {31'b0, addr_ok[1]}, 32'h1);
    check("t4_r_ram_we", {28'b0, ram_we[1]}, 32'h0);
    step(); idle();
    @(negedge clk);
    check("t4_data_ok_c2", {31'b0, data_ok[1]}, 32'h0);
    step();
    @(negedge clk);
    check("t4_w_data_ok", {31'b0, data_ok[1]}, 32'h1);
    check("t4_w_rdata", rdata[1], 32'h0);
    step();
    @(negedge clk);
    check("t4_r_data_ok", {31'b0, data_ok[1]}, 32'h1);
    check("t4_r_rdata", rdata[1], 32'h1122_CCDD);
    step();
    @(negedge clk);
    check("t4_data_ok_c5", {31'b0, data_ok[1]}, 32'h0);

    // ---- inst3 D=3: accept a read, then reset mid-flight ----
    step(); req[3] = 1'b1; addr = 32'h0;
    @(negedge clk);
    check("t5_addr_ok", {31'b0, addr_ok[3]}, 32'h1);
    step(); idle(); reset = 1'b1;
    @(negedge clk);
    check("t5_rst_data_ok", {31'b0, data_ok[3]}, 32'h0);
    check("t5_rst_rdata", rdata[3], 32'h0);
    step();
    step(); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t5_post_data_ok_c%0d", c), {31'b0, data_ok[3]}, 32'h0);
      step();
    end
    req[3] = 1'b1; addr = 32'h4;
    @(negedge clk);
    check("t5_post_addr_ok", {31'b0, addr_ok[3]}, 32'h1);
    for (int c = 1; c < 6; c++) begin
      step(); idle();
      @(negedge clk);
      check($sformatf("t5_new_data_ok_c%0d", c), {31'b0, data_ok[3]}, {31'b0, (c == 4)});
      check($sformatf("t5_new_rdata_c%0d", c), rdata[3], (c == 4) ? 32'h5A00_0001 : 32'h0);
    end

    // ---- inst1: addr_stall for 4 cycles with req held ----
    step(); req[1] = 1'b1; addr = 32'h8;
    @(negedge clk);
    check("t6_addr_ok_c0", {31'b0, addr_ok[1]}, 32'h1);
    for (int c = 1; c < 10; c++) begin
      step(); req[1] = (c <= 5); addr_stall = (c <= 4);
      @(negedge clk);
      if (c <= 5) begin
        check($sformatf("t6_addr_ok_c%0d", c), {31'b0, addr_ok[1]}, {31'b0, (c == 5)});
        check($sformatf("t6_ram_en_c%0d", c), {31'b0, ram_en[1]}, {31'b0, (c == 5)});
      end
      check($sformatf("t6_data_ok_c%0d", c), {31'b0, data_ok[1]}, {31'b0, (c == 3 || c == 8)});
      check($sformatf("t6_rdata_c%0d", c), rdata[1], (c == 3 || c == 8) ? 32'h5A00_0002 : 32'h0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
